data_store_buffer: RTL and testbench

//  Posted-write store buffer between the core's memory stage (MemWriteM/ALUOutM/WriteDataM/ReadDataM)
//  and DataMemory. Stores are queued in a small FIFO and drained to memory in cycles where no load

---
 rtl/data_store_buffer.sv | 128 ++++++++++++
 tb/tb_data_store_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_store_buffer.sv
// -----------------------------------------------------------------------------
// data_store_buffer
//
// Posted-write store buffer sitting between the core's memory stage and the
// data memory. Stores are queued in a small FIFO and written to memory in any
// cycle where no load needs the memory port. Loads see the youngest buffered
// store to the same word, or fall through to memory if there is none.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high; discards pending stores
//   core_we    : store request from the memory stage
//   core_re    : load request from the memory stage
//   core_addr  : word-aligned byte address
//   core_wdata : store data
//   core_rdata : load data back to the core (combinational)
//   stall      : core must hold its memory stage this cycle
//   sb_empty   : no stores pending
//   mem_we     : write strobe to data memory
//   mem_addr   : data memory address
//   mem_wdata  : data memory write data
//   mem_rdata  : data memory combinational read data
//   mem_ready  : memory accepts a write this cycle
// -----------------------------------------------------------------------------
module data_store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_we,
    input  logic                  core_re,
    input  logic [DATA_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  stall,
    output logic                  sb_empty,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Entry storage. Every entry is compared against the load address each
    // cycle, so these must be flops rather than a RAM.
    logic [DATA_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full;
    logic             pop;
    logic             push;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_match;

    // Per-entry validity and word-address match. An entry is live when its
    // distance from head (mod DEPTH) is below the occupancy count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] age;
            assign age              = PTR_W'(gi) - head_q;
            assign entry_valid[gi]  = ({1'b0, age} < count_q);
            assign entry_match[gi]  = entry_valid[gi] &&
                                      (addr_q[gi][DATA_WIDTH-1:2] == core_addr[DATA_WIDTH-1:2]);
        end
    endgenerate

    // Port arbitration, handshake and pointer arithmetic.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        sb_empty  = (count_q == '0);
        mem_we    = ~core_re & (count_q != '0);
        mem_addr  = core_re ? core_addr : addr_q[head_q];
        mem_wdata = data_q[head_q];
        pop       = mem_we & mem_ready;
        // A full buffer can still accept a store when the head drains in the
        // same cycle, so only stall if nothing leaves.
        stall     = core_we & full & ~pop;
        push      = core_we & ~stall;

        head_d    = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d    = push ? tail_q + PTR_W'(1) : tail_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Load forwarding: walk from oldest to youngest so the last hit taken is
    // the youngest matching store.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        core_rdata = mem_rdata;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (entry_match[idx]) begin
                core_rdata = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_q[tail_q] <= core_addr;
            data_q[tail_q] <= core_wdata;
        end
    end

endmodule

// File: tb/tb_data_store_buffer.sv
module tb_data_store_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_we, core_re;
    logic [DW-1:0] core_addr, core_wdata, core_rdata;
    logic          stall, sb_empty, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_store_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_we    (core_we),
        .core_re    (core_re),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .stall      (stall),
        .sb_empty   (sb_empty),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    // Bench-side data memory: 256 words, combinational read, write on accepted strobe.
    logic [31:0] phys_mem [256];
    assign mem_rdata = phys_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we && mem_ready) phys_mem[mem_addr[9:2]] <= mem_wdata;
    end

    // Reference model: a queue of pending stores plus the memory image the
    // stores should have produced.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t        sbq[$];
    logic [31:0] ref_mem [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock of traffic: drive after the falling edge, check combinational
    // outputs against the model, then advance the model at the rising edge.
    task automatic step(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
        logic        busy, exp_pop, exp_stall;
        logic [31:0] exp_rd;
        @(negedge clk);
        core_we = we; core_re = re; core_addr = a; core_wdata = d; mem_ready = rdy;
        assert (!(we && re)) else $error("store and load issued together");
        #1;
        busy      = !re && (sbq.size() != 0);
        exp_pop   = busy && rdy;
        exp_stall = we && (sbq.size() == DEPTH) && !exp_pop;
        $display("t=%0t we=%0d re=%0d addr=%h wdata=%h rdy=%0d pending=%0d",
                 $time, we, re, a, d, rdy, sbq.size());
        check("stall",    {31'b0, stall},    {31'b0, exp_stall});
        check("sb_empty", {31'b0, sb_empty}, {31'b0, sbq.size() == 0});
        check("mem_we",   {31'b0, mem_we},   {31'b0, busy});
        if (re) begin
            exp_rd = ref_mem[a[9:2]];
            for (int i = 0; i < sbq.size(); i++)
                if (sbq[i].a[31:2] == a[31:2]) exp_rd = sbq[i].d;
            check("mem_addr_load", mem_addr, a);
            check("core_rdata", core_rdata, exp_rd);
        end else if (sbq.size() != 0) begin
            check("mem_addr_head",  mem_addr,  sbq[0].a);
            check("mem_wdata_head", mem_wdata, sbq[0].d);
        end
        @(posedge clk);
        if (exp_pop) begin
            ref_mem[sbq[0].a[9:2]] = sbq[0].d;
            void'(sbq.pop_front());
        end
        if (we && !exp_stall) sbq.push_back('{a: a, d: d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; core_we = 1'b0; core_re = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        reset = 1'b0; core_we = 1'b0; core_re = 1'b0;
        core_addr = '0; core_wdata = '0; mem_ready = 1'b1;

        // 1: reset state, single store drains next cycle
        do_reset();
        step(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        drain();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("mem_0x10", phys_mem[4], 32'hDEADBEEF);

        // 2: fill with memory blocked, stall on 5th, then push+pop while full
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), 32'(i + 1), 1'b0);
        step(1'b1, 1'b0, 32'h40, 32'h5, 1'b0);
        step(1'b1, 1'b0, 32'h40, 32'h5, 1'b1);
        drain();

        // 3: forwarding from the youngest of two stores to the same word
        step(1'b1, 1'b0, 32'h20, 32'hAA, 1'b0);
        step(1'b1, 1'b0, 32'h20, 32'hBB, 1'b0);
        step(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h24, 32'h0, 1'b0);
        drain();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("mem_0x20", phys_mem[8], 32'hBB);

        // 4: loads hold off draining
        step(1'b1, 1'b0, 32'h30, 32'h11, 1'b0);
        step(1'b1, 1'b0, 32'h34, 32'h22, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h30, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // 5: pointer wrap with back-to-back stores
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'(32'h100 + i * 4), 32'(32'h1000 + i), 1'b1);
        drain();

        // 6: reset with three pending stores discards them
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(32'h300 + i * 4), 32'(32'hC0DE0 + i), 1'b0);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("discard_0x300", phys_mem[192], 32'h0);

        // Random traffic over a small address window to force collisions
        for (int n = 0; n < 500; n++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 3));
            a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            if (r == 1 || r == 2)
                step(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3) != 0);
            else if (r == 3)
                step(1'b0, 1'b1, a, 32'h0, $urandom_range(0, 3) != 0);
            else
                step(1'b0, 1'b0, a, 32'h0, $urandom_range(0, 3) != 0);
        end
        drain();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        for (int i = 0; i < 256; i++) check($sformatf("mem[%0d]", i), phys_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
